// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// Module   : pipelined_cla_adder
// Purpose  : Pipelined carry-lookahead adder/subtractor with a valid/ready
//            handshake. Optional saturation is enabled by CLA_ADDER_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NG = WIDTH / BLOCK;

  // Per-stage inputs: operands, partial sum and carry into the stage's first group
  logic [WIDTH-1:0]  w_a [STAGES];
  logic [WIDTH-1:0]  w_b [STAGES];
  logic [WIDTH-1:0]  w_s [STAGES];
  logic [STAGES-1:0] w_c;
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_adv;

  assign w_a[0]   = a;
  assign w_b[0]   = b ^ {WIDTH{sub}};
  assign w_s[0]   = '0;
  assign w_c[0]   = cin ^ sub;
  assign w_vin[0] = in_valid;

  // A stage may take new data when it is empty or its successor drains it
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = out_ready | ~w_v[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = ~w_v[k] | w_adv[k+1];
    end
  end

  assign in_ready = w_adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * NG) / STAGES;
    localparam int HI = ((k + 1) * NG) / STAGES;

    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_ns;
    logic             w_t;

    always_comb begin
      w_gg = '0;
      w_gp = '0;
      w_gc = '0;
      w_ns = w_s[k];
      w_t  = 1'b0;
      for (int j = 0; j < NG; j++) begin
        if (j >= LO && j < HI) begin
          w_gp[j] = 1'b1;
          for (int t = 0; t < BLOCK; t++) begin
            w_gg[j] = (w_a[k][j*BLOCK+t] & w_b[k][j*BLOCK+t]) |
                      ((w_a[k][j*BLOCK+t] ^ w_b[k][j*BLOCK+t]) & w_gg[j]);
            w_gp[j] = w_gp[j] & (w_a[k][j*BLOCK+t] ^ w_b[k][j*BLOCK+t]);
          end
        end
      end
      // Group carries as flat sum-of-products over the stage's group G/P terms
      for (int j = 0; j <= NG; j++) begin
        if (j >= LO && j <= HI) begin
          w_gc[j] = w_c[k];
          for (int i = 0; i < NG; i++) begin
            if (i >= LO && i < j) w_gc[j] = w_gc[j] & w_gp[i];
          end
          for (int i = 0; i < NG; i++) begin
            if (i >= LO && i < j) begin
              w_t = w_gg[i];
              for (int m = 0; m < NG; m++) begin
                if (m > i && m < j) w_t = w_t & w_gp[m];
              end
              w_gc[j] = w_gc[j] | w_t;
            end
          end
        end
      end
      for (int j = 0; j < NG; j++) begin
        if (j >= LO && j < HI) begin
          w_t = w_gc[j];
          for (int t = 0; t < BLOCK; t++) begin
            w_ns[j*BLOCK+t] = w_a[k][j*BLOCK+t] ^ w_b[k][j*BLOCK+t] ^ w_t;
            w_t = (w_a[k][j*BLOCK+t] & w_b[k][j*BLOCK+t]) |
                  ((w_a[k][j*BLOCK+t] ^ w_b[k][j*BLOCK+t]) & w_t);
          end
        end
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic             r_v;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_s;
      logic             r_c;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0;
          r_a <= '0;
          r_b <= '0;
          r_s <= '0;
          r_c <= 1'b0;
        end else if (w_adv[k]) begin
          r_v <= w_vin[k];
          if (w_vin[k]) begin
            r_a <= w_a[k];
            r_b <= w_b[k];
            r_s <= w_ns;
            r_c <= w_gc[HI];
          end
        end
      end

      assign w_v[k]     = r_v;
      assign w_vin[k+1] = r_v;
      assign w_a[k+1]   = r_a;
      assign w_b[k+1]   = r_b;
      assign w_s[k+1]   = r_s;
      assign w_c[k+1]   = r_c;
    end else begin : g_last
      logic             w_ovf;
      logic [WIDTH-1:0] w_fin;
      logic             r_v;
      logic [WIDTH-1:0] r_sum;
      logic             r_cout;
      logic             r_ovf;

      assign w_ovf = (w_a[k][WIDTH-1] == w_b[k][WIDTH-1]) &
                     (w_ns[WIDTH-1] != w_a[k][WIDTH-1]);

`ifdef CLA_ADDER_SAT_EN
      localparam logic [WIDTH-1:0] c_smax = {1'b0, {(WIDTH-1){1'b1}}};
      localparam logic [WIDTH-1:0] c_smin = {1'b1, {(WIDTH-1){1'b0}}};
      // Clamp toward the sign of a; the overflow flag still reports the event
      assign w_fin = w_ovf ? (w_a[k][WIDTH-1] ? c_smin : c_smax) : w_ns;
`else
      assign w_fin = w_ns;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v    <= 1'b0;
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
        end else if (w_adv[k]) begin
          r_v <= w_vin[k];
          if (w_vin[k]) begin
            r_sum  <= w_fin;
            r_cout <= w_gc[HI];
            r_ovf  <= w_ovf;
          end
        end
      end

      assign w_v[k]    = r_v;
      assign out_valid = r_v;
      assign sum       = r_sum;
      assign cout      = r_cout;
      assign ovf       = r_ovf;
    end
  end

endmodule

`default_nettype wire
